uart_debug_responder: RTL and testbench

- Synthesizable responder (target side) of the UART debug byte protocol used by the UART boot flow: ACK challenge, READ, WRITE, EXEC and end-of-computation (EOC) report.
- Sits between a UART PHY byte stream and a byte-granular memory request port inside the SoC.
- Parses commands, performs the memory reads and writes, and issues an exec request to the host core.
- Returns the exit code to the host when the core signals EOC.

---
 rtl/uart_debug_responder_if.sv | 38 +++
 rtl/uart_debug_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_debug_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_debug_responder_if.sv
// Byte-stream, memory-port, exec and EOC signals of the UART debug responder.
// Signal suffixes are from the responder's side: slave = responder, master = SoC/PHY side.
interface uart_debug_responder_if #(
    parameter int unsigned AddrWidth = 64
) ();
    logic [7:0]           rx_data_i;
    logic                 rx_valid_i;
    logic                 rx_ready_o;
    logic [7:0]           tx_data_o;
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    logic                 mem_req_o;
    logic                 mem_gnt_i;
    logic                 mem_we_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [7:0]           mem_wdata_o;
    logic                 mem_rvalid_i;
    logic [7:0]           mem_rdata_i;
    logic                 exec_valid_o;
    logic [AddrWidth-1:0] exec_addr_o;
    logic                 eoc_valid_i;
    logic [31:0]          eoc_code_i;
    logic                 eoc_ready_o;

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
               eoc_valid_i, eoc_code_i,
        output rx_ready_o, tx_data_o, tx_valid_o, mem_req_o, mem_we_o, mem_addr_o,
               mem_wdata_o, exec_valid_o, exec_addr_o, eoc_ready_o
    );

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
               eoc_valid_i, eoc_code_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, mem_req_o, mem_we_o, mem_addr_o,
               mem_wdata_o, exec_valid_o, exec_addr_o, eoc_ready_o
    );
endinterface

// File: rtl/uart_debug_responder.sv
// Target side of the UART debug protocol (ACK/READ/WRITE/EXEC/EOC), one memory access in flight.
// Each byte moves on its own valid/ready handshake; tx holds its byte until accepted, rx stalls outside parsing states.
module uart_debug_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LenWidth  = 32,
    parameter logic [7:0]  CmdRead   = 8'h11,
    parameter logic [7:0]  CmdWrite  = 8'h12,
    parameter logic [7:0]  CmdExec   = 8'h13,
    parameter logic [7:0]  Ack       = 8'h06,
    parameter logic [7:0]  Eot       = 8'h04,
    parameter logic [7:0]  Eoc       = 8'h14
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    uart_debug_responder_if.slave   bus,
    output logic                    busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LEN, S_ACK_TX, S_RD_REQ, S_RD_WAIT, S_RD_TX,
        S_WR_RX, S_WR_REQ, S_WR_WAIT, S_EOT_TX, S_EXEC_ACK, S_EXEC_GO, S_EOC_TX
    } state_e;

    typedef enum logic [1:0] {CMD_PING, CMD_READ, CMD_WRITE, CMD_EXEC} cmd_e;

    state_e               state_q, state_d;
    cmd_e                 cmd_q, cmd_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [63:0]          shift_q, shift_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [31:0]          code_q, code_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [AddrWidth-1:0] exec_addr_q, exec_addr_d;
    logic                 init_q;

    logic                 rx_rdy, tx_vld, mem_req, mem_we, exec_vld, eoc_rdy;
    logic [7:0]           tx_dat, mem_wdata;
    logic [AddrWidth-1:0] mem_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_PING;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            code_q      <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            exec_addr_q <= '0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            code_q      <= code_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
            exec_addr_q <= exec_addr_d;
            init_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        len_d       = len_q;
        code_d      = code_q;
        rdata_d     = rdata_q;
        wdata_d     = wdata_q;
        exec_addr_d = exec_addr_q;
        rx_rdy      = 1'b0;
        tx_vld      = 1'b0;
        tx_dat      = 8'h00;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 8'h00;
        exec_vld    = 1'b0;
        eoc_rdy     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // init_q keeps every output low through the first cycle out of reset.
                if (init_q) begin
                    if (bus.eoc_valid_i) begin
                        eoc_rdy = 1'b1;
                        code_d  = bus.eoc_code_i;
                        cnt_d   = '0;
                        state_d = S_EOC_TX;
                    end else begin
                        rx_rdy = 1'b1;
                        if (bus.rx_valid_i) begin
                            cnt_d = '0;
                            if (bus.rx_data_i == Ack) begin
                                cmd_d   = CMD_PING;
                                state_d = S_ACK_TX;
                            end else if (bus.rx_data_i == CmdRead) begin
                                cmd_d   = CMD_READ;
                                state_d = S_ADDR;
                            end else if (bus.rx_data_i == CmdWrite) begin
                                cmd_d   = CMD_WRITE;
                                state_d = S_ADDR;
                            end else if (bus.rx_data_i == CmdExec) begin
                                cmd_d   = CMD_EXEC;
                                state_d = S_ADDR;
                            end
                        end
                    end
                end
            end
            S_ADDR: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) begin
                    // LSB-first bytes enter at the top; after eight the first byte sits at [7:0].
                    shift_d = {bus.rx_data_i, shift_q[63:8]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        addr_d  = shift_d[AddrWidth-1:0];
                        state_d = (cmd_q == CMD_EXEC) ? S_EXEC_ACK : S_LEN;
                    end
                end
            end
            S_LEN: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) begin
                    shift_d = {bus.rx_data_i, shift_q[63:8]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        len_d   = shift_d[LenWidth-1:0];
                        state_d = S_ACK_TX;
                    end
                end
            end
            S_ACK_TX: begin
                tx_vld = 1'b1;
                tx_dat = Ack;
                if (bus.tx_ready_i) begin
                    case (cmd_q)
                        CMD_READ:  state_d = (len_q == '0) ? S_EOT_TX : S_RD_REQ;
                        CMD_WRITE: state_d = (len_q == '0) ? S_EOT_TX : S_WR_RX;
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (bus.mem_gnt_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rdata_d = bus.mem_rdata_i;
                    state_d = S_RD_TX;
                end
            end
            S_RD_TX: begin
                tx_vld = 1'b1;
                tx_dat = rdata_q;
                if (bus.tx_ready_i) begin
                    addr_d  = addr_q + AddrWidth'(1);
                    len_d   = len_q - LenWidth'(1);
                    state_d = (len_q == LenWidth'(1)) ? S_EOT_TX : S_RD_REQ;
                end
            end
            S_WR_RX: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i) begin
                    wdata_d = bus.rx_data_i;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (bus.mem_gnt_i) state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    addr_d  = addr_q + AddrWidth'(1);
                    len_d   = len_q - LenWidth'(1);
                    state_d = (len_q == LenWidth'(1)) ? S_EOT_TX : S_WR_RX;
                end
            end
            S_EOT_TX: begin
                tx_vld = 1'b1;
                tx_dat = Eot;
                if (bus.tx_ready_i) state_d = S_IDLE;
            end
            S_EXEC_ACK: begin
                tx_vld = 1'b1;
                tx_dat = Ack;
                if (bus.tx_ready_i) begin
                    exec_addr_d = addr_q;
                    state_d     = S_EXEC_GO;
                end
            end
            S_EXEC_GO: begin
                exec_vld = 1'b1;
                state_d  = S_IDLE;
            end
            S_EOC_TX: begin
                tx_vld = 1'b1;
                case (cnt_q)
                    3'd0:    tx_dat = Eoc;
                    3'd1:    tx_dat = code_q[7:0];
                    3'd2:    tx_dat = code_q[15:8];
                    3'd3:    tx_dat = code_q[23:16];
                    default: tx_dat = code_q[31:24];
                endcase
                if (bus.tx_ready_i) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd4) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rx_ready_o   = rx_rdy;
    assign bus.tx_valid_o   = tx_vld;
    assign bus.tx_data_o    = tx_dat;
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_wdata_o  = mem_wdata;
    assign bus.exec_valid_o = exec_vld;
    assign bus.exec_addr_o  = exec_addr_q;
    assign bus.eoc_ready_o  = eoc_rdy;
    assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_debug_responder.sv
// Directed bench for uart_debug_responder: vector table of protocol transactions plus hand-written corner cases.
module tb_uart_debug_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_debug_responder_if #(.AddrWidth(64)) bus ();

    uart_debug_responder #(.AddrWidth(64), .LenWidth(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    logic [7:0]  rx_dat = 8'h00;
    logic        rx_vld = 1'b0;
    logic        tx_rdy = 1'b1;
    logic        m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [7:0]  m_rdata = 8'h00;
    logic        eoc_vld = 1'b0;
    logic [31:0] eoc_code = 32'h0;

    assign bus.rx_data_i    = rx_dat;
    assign bus.rx_valid_i   = rx_vld;
    assign bus.tx_ready_i   = tx_rdy;
    assign bus.mem_gnt_i    = m_gnt;
    assign bus.mem_rvalid_i = m_rvalid;
    assign bus.mem_rdata_i  = m_rdata;
    assign bus.eoc_valid_i  = eoc_vld;
    assign bus.eoc_code_i   = eoc_code;

    // Memory model: grant after gnt_delay cycles of request, response one cycle after grant.
    logic [7:0]  mem [logic [63:0]];
    int          gnt_delay = 0, wait_cnt = 0, mem_txn = 0;
    logic [63:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic        pend_we;
    logic [63:0] pend_addr;
    logic [7:0]  pend_wdata;

    always @(negedge clk) begin
        m_rvalid = 1'b0;
        if (!rst_n) begin
            m_gnt    = 1'b0;
            wait_cnt = 0;
        end else if (m_gnt) begin
            m_gnt    = 1'b0;
            m_rvalid = 1'b1;
            mem_txn++;
            if (pend_we) begin
                mem[pend_addr] = pend_wdata;
                wr_addr_q.push_back(pend_addr);
                wr_data_q.push_back(pend_wdata);
                m_rdata = 8'h00;
            end else begin
                m_rdata = mem.exists(pend_addr) ? mem[pend_addr] : 8'h00;
            end
        end else if (bus.mem_req_o) begin
            if (wait_cnt >= gnt_delay) begin
                m_gnt      = 1'b1;
                pend_we    = bus.mem_we_o;
                pend_addr  = bus.mem_addr_o;
                pend_wdata = bus.mem_wdata_o;
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // tx sink: records accepted bytes and counts changes of a byte still waiting to be accepted.
    logic [7:0] txq [$];
    int         stall_until = 0, stab_err = 0, last_tx_cyc = 0;
    logic       prev_pend = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && !(bus.tx_valid_o && bus.tx_data_o == prev_dat)) stab_err++;
            tx_rdy = (cyc >= stall_until);
            if (bus.tx_valid_o && tx_rdy) begin
                txq.push_back(bus.tx_data_o);
                last_tx_cyc = cyc + 1;
                prev_pend   = 1'b0;
            end else begin
                prev_pend = bus.tx_valid_o;
                prev_dat  = bus.tx_data_o;
            end
        end
    end

    int          exec_cnt = 0, exec_run = 0, exec_maxrun = 0, exec_cyc = 0;
    logic [63:0] exec_seen = 64'h0;

    always @(negedge clk) begin
        if (bus.exec_valid_o) begin
            exec_run++;
            if (exec_run == 1) exec_cnt++;
            if (exec_run > exec_maxrun) exec_maxrun = exec_run;
            exec_seen = bus.exec_addr_o;
            exec_cyc  = cyc;
        end else begin
            exec_run = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit ok = 1'b0;
        rx_dat = b;
        rx_vld = 1'b1;
        while (!ok && n < 500) begin
            #1;
            ok = bus.rx_ready_o;
            @(negedge clk);
            n++;
        end
        rx_vld = 1'b0;
        if (!ok) chk("rx_accept_timeout", 64'(n), 64'(0));
    endtask

    task automatic wait_tx(input int base, input int n, input string name);
        int k = 0;
        while ((txq.size() < base + n || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_timeout"}, 64'(k >= 3000), 64'(0));
        repeat (4) @(negedge clk);
    endtask

    task automatic do_eoc(input logic [31:0] code, output int at);
        int n = 0;
        bit ok = 1'b0;
        at       = -1;
        eoc_code = code;
        eoc_vld  = 1'b1;
        while (!ok && n < 3000) begin
            #1;
            ok = bus.eoc_ready_o;
            if (ok) at = txq.size();
            @(negedge clk);
            n++;
        end
        eoc_vld = 1'b0;
        if (!ok) chk("eoc_accept_timeout", 64'(n), 64'(0));
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [63:0] addr, input logic [63:0] len, input bit has_len);
        send_byte(cmd);
        for (int i = 0; i < 8; i++) send_byte(addr[8*i +: 8]);
        if (has_len) for (int i = 0; i < 8; i++) send_byte(len[8*i +: 8]);
    endtask

    function automatic logic [7:0] txat(input int idx);
        return (idx < txq.size()) ? txq[idx] : 8'hxx;
    endfunction

    typedef struct packed {
        logic [19:0][7:0] rx;
        int               n_rx;
        logic [7:0][7:0]  tx;
        int               n_tx;
        int               n_mem;
        bit               chk_wr;
        logic [63:0]      base;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] cmd, input logic [63:0] addr, input logic [63:0] len);
        vec_t v = '0;
        v.rx[0] = cmd;
        for (int i = 0; i < 8; i++) v.rx[1+i] = addr[8*i +: 8];
        for (int i = 0; i < 8; i++) v.rx[9+i] = len[8*i +: 8];
        v.n_rx = 17;
        v.base = addr;
        return v;
    endfunction

    localparam int NV = 9;
    vec_t        vecs [NV];
    logic [7:0]  exp_eoc [11];

    initial begin : main
        int tb, mb, wb, at, n;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rx_ready",   64'(bus.rx_ready_o),   64'(0));
        chk("rst_tx_valid",   64'(bus.tx_valid_o),   64'(0));
        chk("rst_tx_data",    64'(bus.tx_data_o),    64'(0));
        chk("rst_mem_req",    64'(bus.mem_req_o),    64'(0));
        chk("rst_mem_addr",   bus.mem_addr_o,        64'(0));
        chk("rst_exec_valid", 64'(bus.exec_valid_o), 64'(0));
        chk("rst_exec_addr",  bus.exec_addr_o,       64'(0));
        chk("rst_eoc_ready",  64'(bus.eoc_ready_o),  64'(0));
        chk("rst_busy",       64'(busy),             64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '0; vecs[0].rx[0] = 8'h06; vecs[0].n_rx = 1; vecs[0].tx[0] = 8'h06; vecs[0].n_tx = 1;
        vecs[1] = '0; vecs[1].rx[0] = 8'h55; vecs[1].n_rx = 1;
        vecs[2] = mk(8'h12, 64'h1000_0000, 64'd4);
        vecs[2].rx[17] = 8'hDE; vecs[2].rx[18] = 8'hAD; vecs[2].rx[19] = 8'hBE; vecs[2].n_rx = 20;
        vecs[2].tx[0] = 8'h06; vecs[2].tx[1] = 8'h04; vecs[2].n_tx = 2; vecs[2].n_mem = 3;
        vecs[2].chk_wr = 1'b1;
        vecs[2].rx[9] = 8'd3;
        vecs[3] = mk(8'h12, 64'h1000_0003, 64'd1);
        vecs[3].rx[17] = 8'hEF; vecs[3].n_rx = 18;
        vecs[3].tx[0] = 8'h06; vecs[3].tx[1] = 8'h04; vecs[3].n_tx = 2; vecs[3].n_mem = 1; vecs[3].chk_wr = 1'b1;
        vecs[4] = mk(8'h11, 64'h1000_0000, 64'd4);
        vecs[4].tx[0] = 8'h06; vecs[4].tx[1] = 8'hDE; vecs[4].tx[2] = 8'hAD; vecs[4].tx[3] = 8'hBE;
        vecs[4].tx[4] = 8'hEF; vecs[4].tx[5] = 8'h04; vecs[4].n_tx = 6; vecs[4].n_mem = 4;
        vecs[5] = mk(8'h12, 64'h1000_0000, 64'd0);
        vecs[5].tx[0] = 8'h06; vecs[5].tx[1] = 8'h04; vecs[5].n_tx = 2;
        vecs[6] = mk(8'h12, 64'h2000_0000, 64'h1_0000_0000);
        vecs[6].tx[0] = 8'h06; vecs[6].tx[1] = 8'h04; vecs[6].n_tx = 2;
        vecs[7] = mk(8'h12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        vecs[7].rx[17] = 8'h5A; vecs[7].rx[18] = 8'hC3; vecs[7].n_rx = 19;
        vecs[7].tx[0] = 8'h06; vecs[7].tx[1] = 8'h04; vecs[7].n_tx = 2; vecs[7].n_mem = 2; vecs[7].chk_wr = 1'b1;
        vecs[8] = mk(8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        vecs[8].tx[0] = 8'h06; vecs[8].tx[1] = 8'h5A; vecs[8].tx[2] = 8'hC3; vecs[8].tx[3] = 8'h04;
        vecs[8].n_tx = 4; vecs[8].n_mem = 2;

        for (int v = 0; v < NV; v++) begin
            tb = txq.size(); mb = mem_txn; wb = wr_addr_q.size();
            for (int i = 0; i < vecs[v].n_rx; i++) send_byte(vecs[v].rx[i]);
            wait_tx(tb, vecs[v].n_tx, $sformatf("v%0d", v));
            chk($sformatf("v%0d_txcount", v), 64'(txq.size() - tb), 64'(vecs[v].n_tx));
            for (int i = 0; i < vecs[v].n_tx; i++)
                chk($sformatf("v%0d_tx%0d", v, i), 64'(txat(tb + i)), 64'(vecs[v].tx[i]));
            chk($sformatf("v%0d_memtxn", v), 64'(mem_txn - mb), 64'(vecs[v].n_mem));
            if (vecs[v].chk_wr) begin
                for (int i = 0; i < vecs[v].n_mem; i++) begin
                    chk($sformatf("v%0d_wraddr%0d", v, i),
                        (wb + i < wr_addr_q.size()) ? wr_addr_q[wb + i] : 64'hx, vecs[v].base + 64'(i));
                    chk($sformatf("v%0d_wrdata%0d", v, i),
                        64'((wb + i < wr_data_q.size()) ? wr_data_q[wb + i] : 8'hxx), 64'(vecs[v].rx[17 + i]));
                end
            end
        end

        // Ping: busy drops within 3 cycles of the Ack transfer
        tb = txq.size();
        send_byte(8'h06);
        n = 0;
        while (txq.size() < tb + 1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (busy && n < 10) begin @(negedge clk); n++; end
        chk("ping_busy_drop", 64'(n <= 3), 64'(1));
        chk("ping_tx", 64'(txat(tb)), 64'h06);

        // Exec
        tb = txq.size(); n = exec_cnt;
        send_hdr(8'h13, 64'h8000_0000, 64'd0, 1'b0);
        wait_tx(tb, 1, "exec");
        chk("exec_ack", 64'(txat(tb)), 64'h06);
        chk("exec_pulses", 64'(exec_cnt - n), 64'(1));
        chk("exec_width", 64'(exec_maxrun), 64'(1));
        chk("exec_addr_seen", exec_seen, 64'h8000_0000);
        chk("exec_after_ack", 64'(exec_cyc), 64'(last_tx_cyc));
        chk("exec_addr_held", bus.exec_addr_o, 64'h8000_0000);

        // EOC report
        tb = txq.size();
        do_eoc(32'h0000_0003, at);
        wait_tx(tb, 5, "eoc");
        chk("eoc_b0", 64'(txat(tb)),     64'h14);
        chk("eoc_b1", 64'(txat(tb + 1)), 64'h03);
        chk("eoc_b2", 64'(txat(tb + 2)), 64'h00);
        chk("eoc_b3", 64'(txat(tb + 3)), 64'h00);
        chk("eoc_b4", 64'(txat(tb + 4)), 64'h00);

        // Read with delayed grant and 20 cycles of tx backpressure on the data
        gnt_delay = 5;
        tb = txq.size();
        send_hdr(8'h11, 64'h1000_0000, 64'd4, 1'b1);
        n = 0;
        while (txq.size() < tb + 1 && n < 200) begin @(negedge clk); n++; end
        stall_until = cyc + 20;
        wait_tx(tb, 6, "bp");
        chk("bp_count", 64'(txq.size() - tb), 64'(6));
        chk("bp_b1", 64'(txat(tb + 1)), 64'hDE);
        chk("bp_b2", 64'(txat(tb + 2)), 64'hAD);
        chk("bp_b3", 64'(txat(tb + 3)), 64'hBE);
        chk("bp_b4", 64'(txat(tb + 4)), 64'hEF);
        chk("bp_b5", 64'(txat(tb + 5)), 64'h04);
        chk("tx_stable", 64'(stab_err), 64'(0));

        // EOC raised during a READ waits for its EOT
        gnt_delay = 2;
        exp_eoc = '{8'h06, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h04, 8'h14, 8'hD8, 8'hC7, 8'hB6, 8'hA5};
        tb = txq.size();
        send_hdr(8'h11, 64'h1000_0000, 64'd4, 1'b1);
        do_eoc(32'hA5B6_C7D8, at);
        wait_tx(tb, 11, "eocrd");
        chk("eocrd_accept_pos", 64'(at - tb), 64'(6));
        for (int i = 0; i < 11; i++) chk($sformatf("eocrd_b%0d", i), 64'(txat(tb + i)), 64'(exp_eoc[i]));
        gnt_delay = 0;

        // Reset in the middle of a WRITE
        tb = txq.size();
        send_hdr(8'h12, 64'h3000_0000, 64'd4, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_rx_ready",  64'(bus.rx_ready_o),  64'(0));
        chk("mrst_tx_valid",  64'(bus.tx_valid_o),  64'(0));
        chk("mrst_mem_req",   64'(bus.mem_req_o),   64'(0));
        chk("mrst_exec_addr", bus.exec_addr_o,      64'(0));
        chk("mrst_busy",      64'(busy),            64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_no_eot", 64'(txq.size() - tb), 64'(1));
        tb = txq.size();
        send_byte(8'h06);
        wait_tx(tb, 1, "mrst_ping");
        chk("mrst_ping", 64'(txat(tb)), 64'h06);
        chk("mrst_ping_count", 64'(txq.size() - tb), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
